// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Drives a variable-latency imem and skid-buffers one word on stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [15:0] if_id_imm
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        BUFFERED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state;
    logic [31:0] r_pc;
    logic [31:0] w_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] w_buf_instr;
    logic [31:0] r_buf_pc4;
    logic [31:0] w_buf_pc4;
    logic        r_valid;
    logic        w_valid;
    logic [31:0] r_instr;
    logic [31:0] w_instr;
    logic [31:0] r_pc4;
    logic [31:0] w_pc4;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redir_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // Next-state, PC, skid buffer and IF/ID update
    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_buf_instr = r_buf_instr;
        w_buf_pc4   = r_buf_pc4;
        w_valid     = r_valid;
        w_instr     = r_instr;
        w_pc4       = r_pc4;
        if (redirect_valid) begin
            // Redirect drops any returned word and the buffer;
            // IF/ID is left alone.
            w_pc    = w_redir_pc;
            w_state = FETCH;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state = FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        w_pc = w_pc_plus4;
                        if (stall) begin
                            w_buf_instr = imem_rdata;
                            w_buf_pc4   = w_pc_plus4;
                            w_state     = BUFFERED;
                        end else begin
                            w_valid = 1'b1;
                            w_instr = imem_rdata;
                            w_pc4   = w_pc_plus4;
                        end
                    end else if (!stall) begin
                        w_valid = 1'b0;
                        w_instr = 32'h0;
                    end
                end
                BUFFERED: begin
                    if (!stall) begin
                        w_valid = 1'b1;
                        w_instr = r_buf_instr;
                        w_pc4   = r_buf_pc4;
                        w_state = FETCH;
                    end
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
        if (flush) begin
            w_valid = 1'b0;
            w_instr = 32'h0;
        end
    end

    // State, PC, buffer and IF/ID registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_buf_instr <= 32'h0;
            r_buf_pc4   <= 32'h0;
            r_valid     <= 1'b0;
            r_instr     <= 32'h0;
            r_pc4       <= 32'h0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_buf_instr <= w_buf_instr;
            r_buf_pc4   <= w_buf_pc4;
            r_valid     <= w_valid;
            r_instr     <= w_instr;
            r_pc4       <= w_pc4;
        end
    end

    assign imem_req       = (r_state == FETCH);
    assign imem_addr      = r_pc;
    assign if_id_valid    = r_valid;
    assign if_id_instr    = r_instr;
    assign if_id_pc_plus4 = r_pc4;
    assign if_id_imm      = r_instr[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed plan plus random
// traffic against a queue-based behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic [15:0] if_id_imm;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_imm      (if_id_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;

    // Behavioural model: idle flag, PC, pending-word queue, IF/ID
    bit          m_idle;
    logic [31:0] m_pc;
    logic [63:0] m_buf[$];
    bit          m_v;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     n, n_cyc, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit rdy, input bit stl,
                        input bit fl, input bit rd,
                        input logic [31:0] rpc, input bit ovr,
                        input logic [31:0] odata);
        bit          fetching;
        logic [31:0] w;
        exp_t        e;
        @(negedge clk);
        w              = ovr ? odata : pat(m_pc);
        rst_n          = ~rst;
        imem_ready     = rdy;
        imem_rdata     = w;
        stall          = stl;
        flush          = fl;
        redirect_valid = rd;
        redirect_pc    = rpc;
        fetching = !m_idle && (m_buf.size() == 0);
        if (rst) begin
            m_idle  = 1'b1;
            m_pc    = 32'h0;
            m_buf.delete();
            m_v     = 1'b0;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
        end else begin
            if (rd) begin
                m_pc   = {rpc[31:2], 2'b00};
                m_buf.delete();
                m_idle = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (m_buf.size() != 0) begin
                if (!stl) begin
                    {m_instr, m_pc4} = m_buf.pop_front();
                    m_v = 1'b1;
                end
            end else if (fetching && rdy) begin
                if (stl) begin
                    m_buf.push_back({w, m_pc + 32'd4});
                end else begin
                    m_v     = 1'b1;
                    m_instr = w;
                    m_pc4   = m_pc + 32'd4;
                end
                m_pc = m_pc + 32'd4;
            end else if (!stl) begin
                m_v     = 1'b0;
                m_instr = 32'h0;
            end
            if (fl) begin
                m_v     = 1'b0;
                m_instr = 32'h0;
            end
        end
        e.req   = !m_idle && (m_buf.size() == 0);
        e.addr  = m_pc;
        e.v     = m_v;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per edge and compares
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("imem_req", {31'h0, imem_req}, {31'h0, e.req});
                chk("imem_addr", imem_addr, e.addr);
                chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.v});
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
                chk("if_id_imm", {16'h0, if_id_imm}, {16'h0, e.instr[15:0]});
            end
        end
    end

    initial begin
        bit rdy, stl, fl, rd, rs;
        logic [31:0] rpc;
        rst_n          = 1'b0;
        imem_ready     = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        m_idle = 1'b1; m_pc = 0; m_v = 0; m_instr = 0; m_pc4 = 0;
        // reset, then streaming fetch
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        // memory wait states
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // stall on return: skid buffer
        step(0, 1, 1, 0, 0, 0, 1, 32'h2008_FFFF);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // redirect same cycle as ready
        step(0, 1, 0, 0, 1, 32'h0000_0103, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // stall + flush while valid
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        // wrap at top of address space
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // reset while buffered
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(99) < 1);
            rdy = ($urandom_range(99) < 60);
            stl = ($urandom_range(99) < 30);
            fl  = ($urandom_range(99) < 5);
            rd  = ($urandom_range(99) < 5);
            rpc = $urandom;
            if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF8 | rpc[1:0];
            step(rs, rdy, stl, fl, rd, rpc, 0, 0);
        end
        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
